// File: rtl/sram_like_arbiter_if.sv
// sram_like_arbiter_if
//   One sram-like channel: request fields flow master -> slave, ok strobes
//   and read data flow slave -> master.
//   master : drives req/wr/size/addr/wdata, receives rdata/addr_ok/data_ok
//   slave  : receives req/wr/size/addr/wdata, drives rdata/addr_ok/data_ok
interface sram_like_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    modport master (
        output req, wr, size, addr, wdata,
        input  rdata, addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output rdata, addr_ok, data_ok
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
//   Shares a single sram-like bus port between the CPU instruction and data
//   ports, one transaction at a time (address phase, then data phase).
//   Data has fixed priority; a starvation counter forces an instruction grant
//   after STARVE_LIMIT consecutive data grants made while inst_req was pending.
// Ports:
//   clk      : clock, all state updates on the rising edge
//   rstn     : synchronous active-low reset
//   inst_if  : instruction requester (slave side of its channel)
//   data_if  : data requester (slave side of its channel)
//   bus_if   : bus bridge (master side of the shared channel)
//   busy     : high whenever a transaction is in progress
//   owner    : 0 = inst, 1 = data; meaningful while busy
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transaction; arbitrate and latch the owner on a request
// ADDR  | owner's request fields drive the bus, wait for bus_addr_ok
// DATA  | address accepted, wait for bus_data_ok and return rdata
module sram_like_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    sram_like_arbiter_if.slave         inst_if,
    sram_like_arbiter_if.slave         data_if,
    sram_like_arbiter_if.master        bus_if,
    output logic                       busy,
    output logic                       owner
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    logic own_req;
    logic grant_data;

    assign own_req    = owner_q ? data_if.req : inst_if.req;
    // Data wins unless inst is also waiting and has been passed over too often.
    assign grant_data = data_if.req && (!inst_if.req || (starve_cnt_q < LIMIT));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (inst_if.req || data_if.req) begin
                    state_d = S_ADDR;
                    owner_d = grant_data;
                    if (grant_data && inst_if.req) begin
                        starve_cnt_d = (starve_cnt_q >= LIMIT) ? LIMIT
                                                               : starve_cnt_q + CNT_W'(1);
                    end else begin
                        starve_cnt_d = '0;
                    end
                end
            end
            S_ADDR: begin
                if (own_req && bus_if.addr_ok) begin
                    state_d = S_DATA;
                end else if (!own_req) begin
                    // Owner withdrew before acceptance: abandon without a bus cycle.
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (bus_if.data_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are held at zero while rstn is low so that reset silences
    // both ports immediately, including a transaction caught mid-flight.
    always_comb begin
        bus_if.req      = 1'b0;
        bus_if.wr       = 1'b0;
        bus_if.size     = 2'd0;
        bus_if.addr     = 32'd0;
        bus_if.wdata    = 32'd0;
        inst_if.rdata   = 32'd0;
        inst_if.addr_ok = 1'b0;
        inst_if.data_ok = 1'b0;
        data_if.rdata   = 32'd0;
        data_if.addr_ok = 1'b0;
        data_if.data_ok = 1'b0;
        busy            = 1'b0;
        owner           = 1'b0;
        if (rstn) begin
            owner = owner_q;
            case (state_q)
                S_ADDR: begin
                    busy = 1'b1;
                    if (owner_q) begin
                        bus_if.req      = data_if.req;
                        bus_if.wr       = data_if.wr;
                        bus_if.size     = data_if.size;
                        bus_if.addr     = data_if.addr;
                        bus_if.wdata    = data_if.wdata;
                        data_if.addr_ok = bus_if.addr_ok;
                    end else begin
                        bus_if.req      = inst_if.req;
                        bus_if.wr       = inst_if.wr;
                        bus_if.size     = inst_if.size;
                        bus_if.addr     = inst_if.addr;
                        bus_if.wdata    = inst_if.wdata;
                        inst_if.addr_ok = bus_if.addr_ok;
                    end
                end
                S_DATA: begin
                    busy = 1'b1;
                    if (owner_q) begin
                        data_if.data_ok = bus_if.data_ok;
                        data_if.rdata   = bus_if.rdata;
                    end else begin
                        inst_if.data_ok = bus_if.data_ok;
                        inst_if.rdata   = bus_if.rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one sram-like master port between the CPU instruction port and the CPU data port. The block sits between the pipeline's inst/data sram-like interfaces and the single bus bridge.
- Runs one transaction at a time through an address phase and a data phase.
- Data has fixed priority over instruction fetch. A starvation counter forces an instruction grant after a bounded run of back-to-back data grants.

Parameters:
- STARVE_LIMIT, 4: number of consecutive data grants made while inst_req is pending; once reached, the next arbitration is forced to inst. Legal range 1..15.
- CNT_W, 4: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  synchronous reset, active-low
- inst_req  in  1  instruction request valid
- inst_wr  in  1  instruction write (0 in normal use; still forwarded)
- inst_size  in  2  transfer size, 0=byte, 1=half, 2=word
- inst_addr  in  32  instruction address
- inst_wdata  in  32  instruction write data
- inst_rdata  out  32  read data returned to instruction port
- inst_addr_ok  out  1  instruction address accepted
- inst_data_ok  out  1  instruction data phase done
- data_req, data_wr, data_size, data_addr, data_wdata  in  1/1/2/32/32  data port request fields (same meaning as inst_*)
- data_rdata  out  32  read data returned to data port
- data_addr_ok  out  1  data address accepted
- data_data_ok  out  1  data data phase done
- bus_req, bus_wr  out  1  request valid and write flag to slave
- bus_size  out  2  transfer size to slave
- bus_addr, bus_wdata  out  32  address and write data to slave
- bus_rdata  in  32  read data from slave
- bus_addr_ok  in  1  slave accepted address
- bus_data_ok  in  1  slave completed data phase
- busy  out  1  high in any state except IDLE
- owner  out  1  current owner, 0=inst, 1=data; valid when busy

Behaviour:
- Interface rule: one clock `clk`; reset is synchronous, active-low `rstn`, sampled on the rising edge.
- Protocol rules:
  - A handshake completes when req and addr_ok are both high in the same cycle.
  - data_ok arrives at least 1 cycle after its addr handshake.
  - Requesters hold their req fields stable until they see addr_ok.
- States: IDLE, ADDR, DATA. State and owner are registered.
- IDLE:
  - No request: stay in IDLE.
  - Request present: latch the owner and go to ADDR next cycle. This gives 1 cycle of arbitration latency.
  - All bus_* outputs and all *_ok outputs are 0.
- Owner selection in IDLE:
  - Only one requester: that one wins.
  - Both requesting and starve_cnt < STARVE_LIMIT: data wins.
  - Both requesting and starve_cnt >= STARVE_LIMIT: inst wins.
- ADDR:
  - bus_req/wr/size/addr/wdata equal the owner's fields combinationally.
  - {owner}_addr_ok = bus_addr_ok. The non-owner's addr_ok = 0.
  - On bus_req & bus_addr_ok, go to DATA.
  - If the owner drops req (protocol violation): return to IDLE with no bus effect.
- DATA:
  - bus_req = 0; other bus_* outputs = 0.
  - {owner}_data_ok = bus_data_ok and {owner}_rdata = bus_rdata, same cycle with no registering.
  - On bus_data_ok, go to IDLE. A new arbitration therefore starts at the earliest 1 cycle after data_ok.
- Non-owner outputs: rdata = 0, addr_ok = 0, data_ok = 0 in every state.
- starve_cnt (CNT_W bits), updated when the IDLE→ADDR transition fires:
  - Increments when data is granted while inst_req = 1.
  - Clears to 0 when inst is granted, or when data is granted while inst_req = 0.
  - Saturates at STARVE_LIMIT and never wraps.
- bus_data_ok outside DATA, or bus_addr_ok outside ADDR: ignored and not forwarded.
- Reset, including mid-transaction:
  - Next edge forces IDLE, owner = 0, starve_cnt = 0.
  - All outputs 0: bus_*, *_addr_ok, *_data_ok, *_rdata, busy, owner.
  - The outstanding transaction is abandoned; the slave is reset by the same rstn.
- Throughput: at most one transaction in flight; no pipelining of address phases.

Test Plan:
- Reset: hold rstn=0 for 3 cycles with inst_req=data_req=1 → all outputs 0; first cycle after release IDLE, second cycle bus_req=1 with owner=1.
- Single inst read: inst_req, addr=0xBFC00000, size=2; slave addr_ok on cycle 1 of ADDR, data_ok 2 cycles later with rdata=0x3C080001 → inst_addr_ok one pulse, inst_data_ok one pulse carrying 0x3C080001, data_* outputs stay 0.
- Priority: inst and data request together, data write addr=0x80001000, wdata=0xDEADBEEF, wr=1 → data served first with bus_wr=1, bus_wdata=0xDEADBEEF; inst granted at the next IDLE.
- Starvation: data_req held high continuously while inst_req is pending, STARVE_LIMIT=4 → exactly 4 data grants, 5th grant goes to inst, counter returns to 0.
- Reset mid-DATA: assert rstn=0 while waiting for data_ok → next cycle busy=0; a late bus_data_ok=1 after release is not forwarded to either port.
- Back-to-back: bus_addr_ok and bus_data_ok always 1 as soon as legal → each transaction occupies exactly 3 cycles (IDLE, ADDR, DATA); verify ok pulses are 1 cycle wide and never overlap between ports.
